reg_bus_arb: RTL and testbench

REG_BUS_ARB -- requirements
Module: reg_bus_arb

---
 rtl/reg_bus_arb.sv | 149 ++++++++++++++
 tb/tb_reg_bus_arb.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bus_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reg_bus_arb : two-master register-bus arbiter (round-robin; fixed m0 priority
//               when REG_BUS_ARB_FIXED_PRIO_EN is defined)      Rev 1.0
// ---------------------------------------------------------------------------
module reg_bus_arb #(
  parameter int CPU_ADDR_WIDTH = 12,
  parameter int CPU_DATA_WIDTH = 32,
  parameter int RD_LAT         = 2
) (
  input  logic                      clks,
  input  logic                      reset,
  input  logic                      m0_req,
  input  logic                      m0_wr,
  input  logic [CPU_ADDR_WIDTH-1:0] m0_addr,
  input  logic [CPU_DATA_WIDTH-1:0] m0_wdata,
  output logic                      m0_ack,
  output logic [CPU_DATA_WIDTH-1:0] m0_rdata,
  input  logic                      m1_req,
  input  logic                      m1_wr,
  input  logic [CPU_ADDR_WIDTH-1:0] m1_addr,
  input  logic [CPU_DATA_WIDTH-1:0] m1_wdata,
  output logic                      m1_ack,
  output logic [CPU_DATA_WIDTH-1:0] m1_rdata,
  output logic                      cpu_wr,
  output logic                      cpu_rd,
  output logic [CPU_ADDR_WIDTH-1:0] cpu_wr_addr,
  output logic [CPU_DATA_WIDTH-1:0] cpu_data_in,
  input  logic [CPU_DATA_WIDTH-1:0] cpu_data_out,
  output logic                      arb_busy,
  output logic [1:0]                arb_gnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_XFER    = 2'd1;
  localparam logic [1:0] S_RD_WAIT = 2'd2;
  localparam logic [1:0] S_ACK     = 2'd3;

  localparam logic [3:0] WAIT_INIT = 4'(RD_LAT - 1);

  logic [1:0]                state;
  logic                      owner;
  logic                      op_wr;
  logic [3:0]                wait_cnt;
  logic                      pick_m1;
  logic                      sel_wr;
  logic [CPU_ADDR_WIDTH-1:0] sel_addr;
  logic [CPU_DATA_WIDTH-1:0] sel_wdata;

`ifdef REG_BUS_ARB_FIXED_PRIO_EN
  always_comb begin
    pick_m1 = !m0_req;
  end
`else
  logic last_m1;

  // On a tie, the port that did not win last time gets the bus.
  always_comb begin
    pick_m1 = m1_req && (!m0_req || !last_m1);
  end

  always_ff @(posedge clks) begin
    if (reset) begin
      last_m1 <= 1'b1;
    end else if (state == S_IDLE && (m0_req || m1_req)) begin
      last_m1 <= pick_m1;
    end
  end
`endif

  always_comb begin
    sel_wr    = pick_m1 ? m1_wr    : m0_wr;
    sel_addr  = pick_m1 ? m1_addr  : m0_addr;
    sel_wdata = pick_m1 ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clks) begin
    if (reset) begin
      state       <= S_IDLE;
      owner       <= 1'b0;
      op_wr       <= 1'b0;
      wait_cnt    <= '0;
      cpu_wr      <= 1'b0;
      cpu_rd      <= 1'b0;
      cpu_wr_addr <= '0;
      cpu_data_in <= '0;
      m0_ack      <= 1'b0;
      m1_ack      <= 1'b0;
      m0_rdata    <= '0;
      m1_rdata    <= '0;
      arb_busy    <= 1'b0;
      arb_gnt     <= 2'b00;
    end else begin
      cpu_wr <= 1'b0;
      cpu_rd <= 1'b0;
      m0_ack <= 1'b0;
      m1_ack <= 1'b0;
      case (state)
        S_IDLE: begin
          if (m0_req || m1_req) begin
            owner       <= pick_m1;
            op_wr       <= sel_wr;
            cpu_wr_addr <= sel_addr;
            if (sel_wr) begin
              cpu_data_in <= sel_wdata;
            end
            cpu_wr   <= sel_wr;
            cpu_rd   <= !sel_wr;
            arb_busy <= 1'b1;
            arb_gnt  <= pick_m1 ? 2'b10 : 2'b01;
            state    <= S_XFER;
          end
        end
        S_XFER: begin
          if (op_wr) begin
            m0_ack <= !owner;
            m1_ack <= owner;
            state  <= S_ACK;
          end else begin
            wait_cnt <= WAIT_INIT;
            state    <= S_RD_WAIT;
          end
        end
        S_RD_WAIT: begin
          // Address stays put; the bank's registered data is taken on the last wait cycle.
          if (wait_cnt == 4'd0) begin
            if (owner) begin
              m1_rdata <= cpu_data_out;
            end else begin
              m0_rdata <= cpu_data_out;
            end
            m0_ack <= !owner;
            m1_ack <= owner;
            state  <= S_ACK;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        default: begin
          arb_busy <= 1'b0;
          arb_gnt  <= 2'b00;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_reg_bus_arb.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_reg_bus_arb : table vectors, directed corner sequences and random traffic
//                  checked against a transaction-level reference model  Rev 1.0
// ---------------------------------------------------------------------------
module tb_reg_bus_arb;

  localparam int AW     = 12;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;

  logic          clks = 1'b0;
  logic          reset;
  logic          m0_req, m0_wr, m1_req, m1_wr;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_ack, m1_ack;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          cpu_wr, cpu_rd;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_data_in, cpu_data_out;
  logic          arb_busy;
  logic [1:0]    arb_gnt;

  always #5 clks = ~clks;

  reg_bus_arb #(.CPU_ADDR_WIDTH(AW), .CPU_DATA_WIDTH(DW), .RD_LAT(RD_LAT)) dut (
    .clks(clks), .reset(reset),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .cpu_wr(cpu_wr), .cpu_rd(cpu_rd), .cpu_wr_addr(cpu_wr_addr),
    .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .arb_busy(arb_busy), .arb_gnt(arb_gnt)
  );

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return (a == '0) ? 32'h2017_1209 : {20'hB00A5, a};
  endfunction

  // Register bank: registered read data, content defaults to init_val.
  logic [DW-1:0] bank [0:4095];
  bit            bank_w [0:4095];
  always @(posedge clks) begin
    if (cpu_wr) begin
      bank[cpu_wr_addr]   <= cpu_data_in;
      bank_w[cpu_wr_addr] <= 1'b1;
    end
    if (cpu_rd) begin
      cpu_data_out <= bank_w[cpu_wr_addr] ? bank[cpu_wr_addr] : init_val(cpu_wr_addr);
    end
  end

  // Reference model: whole transactions scheduled by cycle number.
  int            cyc = 0;
  int            t_c = 0, done_c = -1;
  bit            has = 0, tw = 0, twr = 0, last_m1 = 1;
  logic [DW-1:0] t_rdata;
  logic [DW-1:0] mm [0:4095];
  bit            mm_w [0:4095];
  logic [AW-1:0] e_addr = '0;
  logic [DW-1:0] e_din = '0, e_rd0 = '0, e_rd1 = '0;
  bit            e_wr, e_rd, e_ack0, e_ack1, e_busy;
  logic [1:0]    e_gnt;

  initial begin
    forever begin
      @(posedge clks);
      cyc++;
      if (reset) begin
        has = 0; done_c = -1; last_m1 = 1;
        e_addr = '0; e_din = '0; e_rd0 = '0; e_rd1 = '0;
      end else if (cyc - 1 > done_c && (m0_req || m1_req)) begin
`ifdef REG_BUS_ARB_FIXED_PRIO_EN
        tw = !m0_req;
`else
        tw = (m0_req && m1_req) ? !last_m1 : m1_req;
`endif
        last_m1 = tw;
        has     = 1;
        t_c     = cyc - 1;
        twr     = tw ? m1_wr : m0_wr;
        e_addr  = tw ? m1_addr : m0_addr;
        if (twr) begin
          e_din          = tw ? m1_wdata : m0_wdata;
          mm[e_addr]     = e_din;
          mm_w[e_addr]   = 1;
          done_c         = t_c + 2;
        end else begin
          t_rdata = mm_w[e_addr] ? mm[e_addr] : init_val(e_addr);
          done_c  = t_c + 2 + RD_LAT;
        end
      end
      e_busy = has && cyc <= done_c;
      e_gnt  = e_busy ? (tw ? 2'b10 : 2'b01) : 2'b00;
      e_wr   = has && cyc == t_c + 1 && twr;
      e_rd   = has && cyc == t_c + 1 && !twr;
      e_ack0 = has && cyc == done_c && !tw;
      e_ack1 = has && cyc == done_c && tw;
      if (has && cyc == done_c && !twr) begin
        if (tw) e_rd1 = t_rdata;
        else    e_rd0 = t_rdata;
      end
    end
  end

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_checks();
    chk("cpu_wr", cpu_wr, e_wr);
    chk("cpu_rd", cpu_rd, e_rd);
    chk("cpu_wr_addr", cpu_wr_addr, e_addr);
    chk("cpu_data_in", cpu_data_in, e_din);
    chk("m0_ack", m0_ack, e_ack0);
    chk("m1_ack", m1_ack, e_ack1);
    chk("m0_rdata", m0_rdata, e_rd0);
    chk("m1_rdata", m1_rdata, e_rd1);
    chk("arb_busy", arb_busy, e_busy);
    chk("arb_gnt", arb_gnt, e_gnt);
    chk("wr_rd_excl", cpu_wr && cpu_rd, 1'b0);
    chk("gnt_onehot0", $countones(arb_gnt) <= 1, 1'b1);
  endtask

  task automatic tick();
    @(negedge clks);
    run_checks();
  endtask

  task automatic set_req(input bit m, input bit rq, input bit wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (m) begin
      m1_req = rq; m1_wr = wr; m1_addr = a; m1_wdata = d;
    end else begin
      m0_req = rq; m0_wr = wr; m0_addr = a; m0_wdata = d;
    end
  endtask

  typedef struct {
    bit            m;
    bit            wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    int            exp_lat;
    logic [DW-1:0] exp_rdata;
  } vec_t;

  vec_t          vecs [6];
  logic [1:0]    gnts [4];
  logic [1:0]    exp_g [4];
  logic [DW-1:0] other;
  bit            rq [2];
  int            gap [2];
  int            lat, n, acks;
  bit            a;

  initial begin
    vecs[0] = '{0, 1, 12'h002, 32'h0000_0005, 2,          32'h0};
    vecs[1] = '{1, 0, 12'h000, 32'h0,         2 + RD_LAT, 32'h2017_1209};
    vecs[2] = '{0, 0, 12'h002, 32'h0,         2 + RD_LAT, 32'h0000_0005};
    vecs[3] = '{1, 1, 12'hFFF, 32'hDEAD_BEEF, 2,          32'h0};
    vecs[4] = '{0, 0, 12'hFFF, 32'h0,         2 + RD_LAT, 32'hDEAD_BEEF};
    vecs[5] = '{1, 0, 12'h002, 32'h0,         2 + RD_LAT, 32'h0000_0005};

    reset = 1'b1;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (3) tick();
    chk("reset_busy", arb_busy, 1'b0);
    chk("reset_rdata0", m0_rdata, '0);
    reset = 1'b0;
    tick();

    foreach (vecs[i]) begin
      other = vecs[i].m ? m0_rdata : m1_rdata;
      set_req(vecs[i].m, 1, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      lat = 0;
      for (int k = 1; k <= 50 && lat == 0; k++) begin
        tick();
        if (k == 1) begin
          chk("vec_strobe", {cpu_wr, cpu_rd}, vecs[i].wr ? 2'b10 : 2'b01);
          chk("vec_addr", cpu_wr_addr, vecs[i].addr);
          if (vecs[i].wr) chk("vec_din", cpu_data_in, vecs[i].wdata);
        end
        if (vecs[i].m ? m1_ack : m0_ack) lat = k;
      end
      chk("vec_ack_lat", lat, vecs[i].exp_lat);
      if (!vecs[i].wr)
        chk("vec_rdata", vecs[i].m ? m1_rdata : m0_rdata, vecs[i].exp_rdata);
      chk("vec_other_rdata", vecs[i].m ? m0_rdata : m1_rdata, other);
      set_req(vecs[i].m, 0, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      repeat (2) tick();
    end

    // Both masters hold read requests continuously after a reset.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    set_req(0, 1, 0, 12'h001, '0);
    set_req(1, 1, 0, 12'h002, '0);
    n = 0;
    for (int k = 0; k < 100 && n < 4; k++) begin
      tick();
      if (cpu_rd) begin
        gnts[n] = arb_gnt;
        n++;
      end
    end
    chk("rr_grant_count", n, 4);
`ifdef REG_BUS_ARB_FIXED_PRIO_EN
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b01};
`else
    exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
`endif
    for (int i = 0; i < 4; i++) chk("rr_grant_order", gnts[i], exp_g[i]);
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (8) tick();

    // Reset during the first read-wait cycle abandons the transaction.
    set_req(0, 1, 0, 12'h003, '0);
    repeat (2) tick();
    chk("rdwait_busy", arb_busy, 1'b1);
    reset = 1'b1;
    set_req(0, 0, 0, '0, '0);
    tick();
    chk("rst_mid_busy", arb_busy, 1'b0);
    chk("rst_mid_gnt", arb_gnt, 2'b00);
    chk("rst_mid_ack", {m0_ack, m1_ack}, 2'b00);
    chk("rst_mid_addr", cpu_wr_addr, '0);
    chk("rst_mid_rdata", {m0_rdata, m1_rdata}, '0);
    reset = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      acks += int'(m0_ack) + int'(m1_ack);
    end
    chk("rst_mid_no_ack", acks, 0);

    // m1 drops its request while in XFER; the access still completes.
    set_req(1, 1, 1, 12'h005, 32'h0000_0055);
    tick();
    chk("drop_xfer_strobe", cpu_wr, 1'b1);
    set_req(1, 0, 1, 12'h005, 32'h0000_0055);
    acks = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      acks += int'(m1_ack);
    end
    chk("drop_ack_once", acks, 1);
    chk("drop_idle", arb_busy, 1'b0);

    // Random traffic; the per-cycle model comparison does the checking.
    rq[0] = 0; rq[1] = 0; gap[0] = 0; gap[1] = 1;
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int i = 0; i < 2; i++) begin
        a = (i == 1) ? m1_ack : m0_ack;
        if (rq[i]) begin
          if (a) begin
            rq[i]  = 0;
            gap[i] = $urandom_range(0, 3);
            set_req(i[0], 0, 0, '0, '0);
          end
        end else if (gap[i] == 0) begin
          rq[i] = 1;
          set_req(i[0], 1, $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15)),
                  $urandom);
        end else begin
          gap[i]--;
        end
      end
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (10) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
